mvau_inp_buf_ctrl: RTL and testbench

Sequencing controller for the MVAU stream input buffer. Accepts one input-activation vector (SF words of SIMD×TSrcI bits) from the upstream stream, writes it into the buffer in write-through mode while forwarding it to the compute stage, then replays it NF−1 more times, once per neuron fold. It generates the buffer's write enable, read enable and address, plus the framing flags for the accumulators. It sits in mvau_stream between the input AXI-stream handshake and the input buffer/PE array.

---
 rtl/mvau_pkg.sv | 19 +
 rtl/mvau_inp_buf_ctrl_if.sv | 29 ++
 rtl/mvau_fold_cnt.sv | 42 ++++
 rtl/mvau_inp_buf_ctrl.sv | 122 ++++++++++++
 tb/tb_mvau_inp_buf_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/mvau_pkg.sv
// Shared definitions for the MVAU stream input path: controller state
// encoding and the buffer/fold counter width rule.
package mvau_pkg;

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } state_e;

  // Counter/address width for a range of n values, never narrower than one bit.
  function automatic int buf_addr_w(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/mvau_inp_buf_ctrl_if.sv
// Handshake and buffer-control bundle between the MVAU input buffer
// controller (master) and its environment (slave).
interface mvau_inp_buf_ctrl_if #(
  parameter int BUF_ADDR = 4
);
  logic                in_v;
  logic                in_rdy;
  logic                cons_rdy;
  logic                buf_wr_en;
  logic                buf_rd_en;
  logic [BUF_ADDR-1:0] buf_addr;
  logic                out_v;
  logic                out_sf_first;
  logic                out_sf_last;
  logic                out_nf_last;
  logic                vec_done;

  modport master (
    input  in_v, cons_rdy,
    output in_rdy, buf_wr_en, buf_rd_en, buf_addr,
           out_v, out_sf_first, out_sf_last, out_nf_last, vec_done
  );

  modport slave (
    output in_v, cons_rdy,
    input  in_rdy, buf_wr_en, buf_rd_en, buf_addr,
           out_v, out_sf_first, out_sf_last, out_nf_last, vec_done
  );
endinterface

// File: rtl/mvau_fold_cnt.sv
// Wrap counter 0..MAX-1 advancing on en_i; last_o flags the terminal count.
module mvau_fold_cnt #(
  parameter int MAX = 4,
  parameter int W   = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign last_o = (cnt_q == W'(MAX - 1));
  assign cnt_o  = cnt_q;

  // Next count: hold, increment, or wrap to zero after the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (last_o) begin
        cnt_d = W'(0);
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= W'(0);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mvau_inp_buf_ctrl.sv
// MVAU input buffer sequencer: writes one activation vector through the
// buffer during FILL while forwarding it, then replays it for the remaining
// neuron folds. Framing flags are registered once to line up with the
// buffer's one-cycle output register.
module mvau_inp_buf_ctrl
  import mvau_pkg::*;
#(
  parameter int SF       = 16,
  parameter int NF       = 4,
  parameter int BUF_ADDR = buf_addr_w(SF)
) (
  input  logic                  aclk,
  input  logic                  areset,
  mvau_inp_buf_ctrl_if.master   bus
);

  localparam int NF_W = buf_addr_w(NF);

  state_e              state_q;
  state_e              state_d;
  logic                issue_s;
  logic                wr_s;
  logic                rd_s;
  logic [BUF_ADDR-1:0] sf_cnt_s;
  logic [NF_W-1:0]     nf_cnt_s;
  logic                sf_last_s;
  logic                nf_last_s;
  logic                fold0_s;
  logic                out_v_q;
  logic                out_sf_first_q;
  logic                out_sf_last_q;
  logic                out_nf_last_q;
  logic                vec_done_q;

  assign fold0_s = (nf_cnt_s == NF_W'(0));

  // Word position inside the current fold.
  mvau_fold_cnt #(
    .MAX (SF),
    .W   (BUF_ADDR)
  ) u_sf_cnt (
    .clk_i  (aclk),
    .rst_i  (areset),
    .en_i   (issue_s),
    .cnt_o  (sf_cnt_s),
    .last_o (sf_last_s)
  );

  // Fold index; advances only when a fold's last word issues.
  mvau_fold_cnt #(
    .MAX (NF),
    .W   (NF_W)
  ) u_nf_cnt (
    .clk_i  (aclk),
    .rst_i  (areset),
    .en_i   (issue_s & sf_last_s),
    .cnt_o  (nf_cnt_s),
    .last_o (nf_last_s)
  );

  // Issue decision, buffer strobes and next state; reset blocks any issue.
  always_comb begin
    issue_s = 1'b0;
    wr_s    = 1'b0;
    rd_s    = 1'b0;
    state_d = state_q;
    case (state_q)
      FILL: begin
        issue_s = ~areset & bus.in_v & bus.cons_rdy;
        wr_s    = issue_s;
        if (issue_s && sf_last_s && fold0_s && !nf_last_s) begin
          state_d = REPLAY;
        end else begin
          state_d = FILL;
        end
      end
      REPLAY: begin
        issue_s = ~areset & bus.cons_rdy;
        rd_s    = issue_s;
        if (issue_s && sf_last_s && nf_last_s) begin
          state_d = FILL;
        end else begin
          state_d = REPLAY;
        end
      end
      default: begin
        issue_s = 1'b0;
        state_d = FILL;
      end
    endcase
  end

  // State register plus issue-cycle framing flags delayed by one cycle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q        <= FILL;
      out_v_q        <= 1'b0;
      out_sf_first_q <= 1'b0;
      out_sf_last_q  <= 1'b0;
      out_nf_last_q  <= 1'b0;
      vec_done_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_v_q        <= issue_s;
      out_sf_first_q <= issue_s & (sf_cnt_s == BUF_ADDR'(0));
      out_sf_last_q  <= issue_s & sf_last_s;
      out_nf_last_q  <= issue_s & nf_last_s;
      vec_done_q     <= issue_s & sf_last_s & nf_last_s;
    end
  end

  assign bus.in_rdy       = ~areset & bus.cons_rdy & (state_q == FILL);
  assign bus.buf_wr_en    = wr_s;
  assign bus.buf_rd_en    = rd_s;
  assign bus.buf_addr     = sf_cnt_s;
  assign bus.out_v        = out_v_q;
  assign bus.out_sf_first = out_sf_first_q;
  assign bus.out_sf_last  = out_sf_last_q;
  assign bus.out_nf_last  = out_nf_last_q;
  assign bus.vec_done     = vec_done_q;

endmodule

// File: tb/tb_mvau_inp_buf_ctrl.sv
// Directed bench for mvau_inp_buf_ctrl: three configurations (4x3, 2x1,
// 1x2) with a behavioural write-through buffer to follow the data words.
module tb_mvau_inp_buf_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  mvau_inp_buf_ctrl_if #(.BUF_ADDR(2)) ifa ();
  mvau_inp_buf_ctrl_if #(.BUF_ADDR(1)) ifb ();
  mvau_inp_buf_ctrl_if #(.BUF_ADDR(1)) ifc ();

  mvau_inp_buf_ctrl #(.SF(4), .NF(3), .BUF_ADDR(2)) dut_a (.aclk(clk), .areset(rst), .bus(ifa));
  mvau_inp_buf_ctrl #(.SF(2), .NF(1), .BUF_ADDR(1)) dut_b (.aclk(clk), .areset(rst), .bus(ifb));
  mvau_inp_buf_ctrl #(.SF(1), .NF(2), .BUF_ADDR(1)) dut_c (.aclk(clk), .areset(rst), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural write-through buffers, one per instance.
  logic [7:0] din_a, din_b, din_c;
  logic [7:0] mem_a [4];
  logic [7:0] mem_b [2];
  logic [7:0] mem_c [2];
  logic [7:0] dout_a, dout_b, dout_c;

  // Buffer model: write-through on write, registered read otherwise.
  always @(posedge clk) begin
    if (ifa.buf_wr_en) begin mem_a[ifa.buf_addr] <= din_a; dout_a <= din_a; end
    else if (ifa.buf_rd_en) dout_a <= mem_a[ifa.buf_addr];
    if (ifb.buf_wr_en) begin mem_b[ifb.buf_addr] <= din_b; dout_b <= din_b; end
    else if (ifb.buf_rd_en) dout_b <= mem_b[ifb.buf_addr];
    if (ifc.buf_wr_en) begin mem_c[ifc.buf_addr] <= din_c; dout_c <= din_c; end
    else if (ifc.buf_rd_en) dout_c <= mem_c[ifc.buf_addr];
  end

  // Issue-cycle (combinational) and registered observations of one tick.
  logic [31:0] c_addr;
  logic        c_wr, c_rd, c_rdy;
  logic        r_v, r_first, r_last, r_nlast, r_done;
  logic [7:0]  r_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle into the selected instance (others idle), capture results.
  task automatic tick(input int sel, input logic v, input logic c, input logic [7:0] d);
    ifa.in_v = 1'b0; ifa.cons_rdy = 1'b0;
    ifb.in_v = 1'b0; ifb.cons_rdy = 1'b0;
    ifc.in_v = 1'b0; ifc.cons_rdy = 1'b0;
    case (sel)
      0: begin ifa.in_v = v; ifa.cons_rdy = c; din_a = d; end
      1: begin ifb.in_v = v; ifb.cons_rdy = c; din_b = d; end
      default: begin ifc.in_v = v; ifc.cons_rdy = c; din_c = d; end
    endcase
    #1;
    case (sel)
      0: begin c_addr = 32'(ifa.buf_addr); c_wr = ifa.buf_wr_en; c_rd = ifa.buf_rd_en; c_rdy = ifa.in_rdy; end
      1: begin c_addr = 32'(ifb.buf_addr); c_wr = ifb.buf_wr_en; c_rd = ifb.buf_rd_en; c_rdy = ifb.in_rdy; end
      default: begin c_addr = 32'(ifc.buf_addr); c_wr = ifc.buf_wr_en; c_rd = ifc.buf_rd_en; c_rdy = ifc.in_rdy; end
    endcase
    @(negedge clk);
    case (sel)
      0: begin r_v = ifa.out_v; r_first = ifa.out_sf_first; r_last = ifa.out_sf_last;
               r_nlast = ifa.out_nf_last; r_done = ifa.vec_done; r_data = dout_a; end
      1: begin r_v = ifb.out_v; r_first = ifb.out_sf_first; r_last = ifb.out_sf_last;
               r_nlast = ifb.out_nf_last; r_done = ifb.vec_done; r_data = dout_b; end
      default: begin r_v = ifc.out_v; r_first = ifc.out_sf_first; r_last = ifc.out_sf_last;
               r_nlast = ifc.out_nf_last; r_done = ifc.vec_done; r_data = dout_c; end
    endcase
  endtask

  // One full 4x3 vector A,B,C,D on instance a with an optional stall:
  // kind 0 drops cons_rdy, kind 1 drops in_v, for len cycles before word at.
  task automatic run_vec_a(input string nm, input int kind, input int at, input int len);
    int j = 0;
    int s = 0;
    int guard = 0;
    while (j < 12 && guard < 40) begin
      guard++;
      if (j == at && s < len) begin
        tick(0, kind == 1 ? 1'b0 : 1'b1, kind == 0 ? 1'b0 : 1'b1, 8'hEE);
        check({nm, " stall addr"}, c_addr, 32'(j % 4));
        check({nm, " stall wr"}, 32'(c_wr), 32'd0);
        check({nm, " stall rd"}, 32'(c_rd), 32'd0);
        check({nm, " stall rdy"}, 32'(c_rdy), kind == 1 ? 32'd1 : 32'd0);
        check({nm, " stall out_v"}, 32'(r_v), 32'd0);
        s++;
      end else begin
        tick(0, 1'b1, 1'b1, 8'h0A + 8'(j % 4));
        check({nm, " addr"}, c_addr, 32'(j % 4));
        check({nm, " wr"}, 32'(c_wr), 32'(j < 4));
        check({nm, " rd"}, 32'(c_rd), 32'(j >= 4));
        check({nm, " rdy"}, 32'(c_rdy), 32'(j < 4));
        check({nm, " out_v"}, 32'(r_v), 32'd1);
        check({nm, " data"}, 32'(r_data), 32'h0A + 32'(j % 4));
        check({nm, " sf_first"}, 32'(r_first), 32'(j % 4 == 0));
        check({nm, " sf_last"}, 32'(r_last), 32'(j % 4 == 3));
        check({nm, " nf_last"}, 32'(r_nlast), 32'(j >= 8));
        check({nm, " vec_done"}, 32'(r_done), 32'(j == 11));
        j++;
      end
    end
    check({nm, " budget"}, 32'(j), 32'd12);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    din_a = 8'h00; din_b = 8'h00; din_c = 8'h00;
    ifa.in_v = 1'b1; ifa.cons_rdy = 1'b1;
    ifb.in_v = 1'b0; ifb.cons_rdy = 1'b0;
    ifc.in_v = 1'b0; ifc.cons_rdy = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset in_rdy", 32'(ifa.in_rdy), 32'd0);
    check("reset wr", 32'(ifa.buf_wr_en), 32'd0);
    check("reset out_v", 32'(ifa.out_v), 32'd0);
    check("reset vec_done", 32'(ifa.vec_done), 32'd0);
    check("reset addr", 32'(ifa.buf_addr), 32'd0);
    rst = 1'b0;

    // Straight vector, cons_rdy stall in fold 1 word 2, in_v gap after word 1.
    run_vec_a("plain", 0, 99, 0);
    run_vec_a("cstall", 0, 6, 2);
    run_vec_a("vgap", 1, 2, 3);
    tick(0, 1'b0, 1'b1, 8'h00);
    check("idle out_v", 32'(r_v), 32'd0);
    check("idle rdy", 32'(c_rdy), 32'd1);

    // SF=2, NF=1 back to back: always FILL, done every second word.
    for (int j = 0; j < 6; j++) begin
      tick(1, 1'b1, 1'b1, 8'h20 + 8'(j));
      check("b rdy", 32'(c_rdy), 32'd1);
      check("b wr", 32'(c_wr), 32'd1);
      check("b rd", 32'(c_rd), 32'd0);
      check("b addr", c_addr, 32'(j % 2));
      check("b data", 32'(r_data), 32'h20 + 32'(j));
      check("b sf_first", 32'(r_first), 32'(j % 2 == 0));
      check("b sf_last", 32'(r_last), 32'(j % 2 == 1));
      check("b nf_last", 32'(r_nlast), 32'd1);
      check("b vec_done", 32'(r_done), 32'(j % 2 == 1));
    end

    // SF=1, NF=2: every word frames a fold, every second closes the vector.
    for (int j = 0; j < 4; j++) begin
      tick(2, 1'b1, 1'b1, 8'h30 + 8'(j));
      check("c rdy", 32'(c_rdy), 32'(j % 2 == 0));
      check("c wr", 32'(c_wr), 32'(j % 2 == 0));
      check("c rd", 32'(c_rd), 32'(j % 2 == 1));
      check("c addr", c_addr, 32'd0);
      check("c data", 32'(r_data), 32'h30 + 32'(j - (j % 2)));
      check("c sf_first", 32'(r_first), 32'd1);
      check("c sf_last", 32'(r_last), 32'd1);
      check("c nf_last", 32'(r_nlast), 32'(j % 2 == 1));
      check("c vec_done", 32'(r_done), 32'(j % 2 == 1));
    end

    // Reset at fold 1 word 1 of instance a, then restart from word 0.
    for (int j = 0; j < 5; j++) tick(0, 1'b1, 1'b1, 8'h0A + 8'(j % 4));
    ifa.in_v = 1'b1; ifa.cons_rdy = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("rst out_v", 32'(ifa.out_v), 32'd0);
    check("rst sf_first", 32'(ifa.out_sf_first), 32'd0);
    check("rst nf_last", 32'(ifa.out_nf_last), 32'd0);
    check("rst rd", 32'(ifa.buf_rd_en), 32'd0);
    check("rst wr", 32'(ifa.buf_wr_en), 32'd0);
    check("rst rdy", 32'(ifa.in_rdy), 32'd0);
    check("rst addr", 32'(ifa.buf_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(0, 1'b1, 1'b1, 8'h55);
    check("post addr", c_addr, 32'd0);
    check("post wr", 32'(c_wr), 32'd1);
    check("post rdy", 32'(c_rdy), 32'd1);
    check("post out_v", 32'(r_v), 32'd1);
    check("post sf_first", 32'(r_first), 32'd1);
    check("post nf_last", 32'(r_nlast), 32'd0);
    check("post data", 32'(r_data), 32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
